// File: rtl/complex_mul.sv
// ---------------------------------------------------------------------------
// complex_mul
//
// Two-stage pipelined signed complex multiplier for the FFT butterfly
// datapath. Computes (in1 + j*in1i) * (in2 + j*in2i) on 32-bit two's
// complement operands and returns 32-bit real/imaginary results two clock
// edges after the operands are accepted. One operation may be issued per
// cycle; there is no backpressure.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (clears every pipeline register)
//   in_valid   operands on in1/in1i/in2/in2i are valid this cycle
//   in1, in1i  real / imaginary part of operand A (signed, 32 bits)
//   in2, in2i  real / imaginary part of operand B (signed, 32 bits)
//   out_valid  O/Oi carry a new result this cycle
//   O, Oi      real / imaginary result (signed, 32 bits); they hold their
//              last value while out_valid is low
//
// Configuration macro:
//   CMPX_MUL_SAT_EN  when defined, stage 2 saturates the 65-bit sum/difference
//                    to [-2^31, 2^31-1]; when undefined (default) the result
//                    wraps to the low 32 bits. Latency is the same either way.
// ---------------------------------------------------------------------------
module complex_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in1,
  input  logic [31:0] in1i,
  input  logic [31:0] in2,
  input  logic [31:0] in2i,
  output logic        out_valid,
  output logic [31:0] O,
  output logic [31:0] Oi
);

  // Operands sign-extended to 64 bits so each product is exact.
  logic signed [63:0] a_re, a_im, b_re, b_im;

  // Stage 1 registers: the four full-width products and their valid bit.
  logic signed [63:0] p_rr, p_ii, p_ri, p_ir;
  logic               v1;

  // 65-bit difference/sum: one guard bit so neither can overflow.
  logic [64:0] re_diff, im_sum;

  // Stage 2 inputs after reduction to 32 bits.
  logic [31:0] re_red, im_red;

  assign a_re = {{32{in1[31]}},  in1};
  assign a_im = {{32{in1i[31]}}, in1i};
  assign b_re = {{32{in2[31]}},  in2};
  assign b_im = {{32{in2i[31]}}, in2i};

  // Stage 1: products are captured every cycle; the data is only meaningful
  // when v1 is set, so idle slots may load don't-care values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
    end else begin
      v1   <= in_valid;
      p_rr <= a_re * b_re;
      p_ii <= a_im * b_im;
      p_ri <= a_re * b_im;
      p_ir <= a_im * b_re;
    end
  end

  assign re_diff = {p_rr[63], p_rr} - {p_ii[63], p_ii};
  assign im_sum  = {p_ri[63], p_ri} + {p_ir[63], p_ir};

`ifdef CMPX_MUL_SAT_EN
  // The value fits in 32 signed bits exactly when bits 64..31 are all copies
  // of the sign bit; otherwise clamp toward the sign of the 65-bit value.
  function automatic logic [31:0] saturate(input logic [64:0] x);
    if (x[64:31] == {34{x[64]}})
      return x[31:0];
    else if (x[64])
      return 32'h8000_0000;
    else
      return 32'h7FFF_FFFF;
  endfunction

  assign re_red = saturate(re_diff);
  assign im_red = saturate(im_sum);
`else
  // Wrap-around: keep the low 32 bits. The upper bits are intentionally
  // discarded; folding them into a named sink keeps that explicit.
  logic unused_high;
  assign re_red      = re_diff[31:0];
  assign im_red      = im_sum[31:0];
  assign unused_high = ^{re_diff[64:32], im_sum[64:32]};
`endif

  // Stage 2: results only overwrite O/Oi for a valid slot so the outputs
  // hold steady across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      O         <= '0;
      Oi        <= '0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        O  <= re_red;
        Oi <= im_red;
      end
    end
  end

endmodule

// File: tb/tb_complex_mul.sv
// ---------------------------------------------------------------------------
// tb_complex_mul
//
// Self-checking bench for complex_mul. Directed steps in one initial block
// push expected results into a scoreboard queue as operands are driven; a
// monitor on the falling clock edge pops and compares whenever out_valid is
// high, checks out_valid against the expected 2-cycle delayed pattern, and
// checks that O/Oi hold their last value while out_valid is low.
// Build with +define+CMPX_MUL_SAT_EN to check the saturating variant.
// ---------------------------------------------------------------------------
module tb_complex_mul;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in1, in1i, in2, in2i;
  logic        out_valid;
  logic [31:0] O, Oi;

  typedef struct packed {
    logic [31:0] o;
    logic [31:0] oi;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_o   = 32'h0;
  logic [31:0] last_oi  = 32'h0;
  logic        ev1, ev2;

  complex_mul dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in1       (in1),
    .in1i      (in1i),
    .in2       (in2),
    .in2i      (in2i),
    .out_valid (out_valid),
    .O         (O),
    .Oi        (Oi)
  );

  // 10 ns clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected out_valid: accepted in_valid delayed by two edges, killed by reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ev1 <= 1'b0;
      ev2 <= 1'b0;
    end else begin
      ev1 <= in_valid;
      ev2 <= ev1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp_val);
    checks++;
    assert (obs === exp_val) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp_val);
    end
  endtask

  // Reference model: exact products, 65-bit sum/difference, then wrap or clamp.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] ai,
                                 input logic [31:0] b, input logic [31:0] bi);
    longint            ar, aim, br, bim;
    logic signed [64:0] re, im;
    exp_t               r;
    ar  = longint'($signed(a));
    aim = longint'($signed(ai));
    br  = longint'($signed(b));
    bim = longint'($signed(bi));
    re  = 65'(ar * br) - 65'(aim * bim);
    im  = 65'(ar * bim) + 65'(aim * br);
`ifdef CMPX_MUL_SAT_EN
    if (re > 65'sd2147483647)       r.o = 32'h7FFF_FFFF;
    else if (re < -65'sd2147483648) r.o = 32'h8000_0000;
    else                            r.o = re[31:0];
    if (im > 65'sd2147483647)       r.oi = 32'h7FFF_FFFF;
    else if (im < -65'sd2147483648) r.oi = 32'h8000_0000;
    else                            r.oi = im[31:0];
`else
    r.o  = re[31:0];
    r.oi = im[31:0];
`endif
    return r;
  endfunction

  // Monitor: sample away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    checkOutput("out_valid", {31'b0, out_valid}, {31'b0, ev2});
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        checkOutput("O", O, e.o);
        checkOutput("Oi", Oi, e.oi);
        last_o  = e.o;
        last_oi = e.oi;
      end
    end else begin
      checkOutput("O_hold", O, last_o);
      checkOutput("Oi_hold", Oi, last_oi);
    end
  end

  // Drive one valid operand pair for one cycle and record its expected result.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] ai,
                               input logic [31:0] b, input logic [31:0] bi,
                               input logic [31:0] eo, input logic [31:0] eoi);
    exp_t e;
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    in1  = a;
    in1i = ai;
    in2  = b;
    in2i = bi;
    e.o  = eo;
    e.oi = eoi;
    sb.push_back(e);
  endtask

  task automatic applyModeled(input logic [31:0] a, input logic [31:0] ai,
                              input logic [31:0] b, input logic [31:0] bi);
    exp_t e;
    e = model(a, ai, b, bi);
    applyStimulus(a, ai, b, bi, e.o, e.oi);
  endtask

  // Bubble slot with junk on the data inputs.
  task automatic applyIdle();
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    in1  = $urandom;
    in1i = $urandom;
    in2  = $urandom;
    in2i = $urandom;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in1      = '0;
    in1i     = '0;
    in2      = '0;
    in2i     = '0;

    #1;
    checkOutput("reset_O", O, 32'h0);
    checkOutput("reset_Oi", Oi, 32'h0);
    checkOutput("reset_valid", {31'b0, out_valid}, 32'h0);

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Basic single operation, then a gap.
    applyStimulus(32'd1, 32'd2, 32'd4, 32'd2, 32'd0, 32'd10);
    repeat (3) applyIdle();

    // Signs.
    applyStimulus(-32'sd3, 32'd5, 32'd2, -32'sd7, 32'd29, 32'd31);
    applyStimulus(32'd0, 32'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd0);
    applyIdle();

    // Streaming back-to-back.
    applyStimulus(32'd1, 32'd0, 32'd5, 32'd6, 32'd5, 32'd6);
    applyStimulus(32'd2, 32'd0, 32'd5, 32'd6, 32'd10, 32'd12);
    applyStimulus(32'd0, 32'd1, 32'd5, 32'd6, -32'sd6, 32'd5);
    applyIdle();

    // Overflow boundaries.
`ifdef CMPX_MUL_SAT_EN
    applyStimulus(32'h7FFF_FFFF, 32'd0, 32'd2, 32'd0, 32'h7FFF_FFFF, 32'd0);
    applyStimulus(32'h8000_0000, 32'd0, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 32'd0);
    applyStimulus(32'h8000_0000, 32'd0, 32'd2, 32'd0, 32'h8000_0000, 32'd0);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                  32'd0, 32'h7FFF_FFFF);
`else
    applyStimulus(32'h7FFF_FFFF, 32'd0, 32'd2, 32'd0, 32'hFFFF_FFFE, 32'd0);
    applyStimulus(32'h8000_0000, 32'd0, 32'h8000_0000, 32'd0, 32'd0, 32'd0);
    applyStimulus(32'h8000_0000, 32'd0, 32'd2, 32'd0, 32'd0, 32'd0);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                  32'd0, 32'd0);
`endif
    applyIdle();

    // Random back-to-back stream checked against the model.
    for (int i = 0; i < 8; i++) applyModeled($urandom, $urandom, $urandom, $urandom);

    // Bubbles: alternate valid / idle over six cycles.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) applyModeled($urandom, $urandom, $urandom, $urandom);
      else            applyIdle();
    end
    repeat (3) applyIdle();

    // Reset mid-flight: first result reports, second is in stage 1 when
    // reset asserts between edges and must be discarded.
    applyStimulus(32'd3, 32'd4, 32'd5, 32'd6, -32'sd9, 32'd38);
    applyStimulus(32'd7, 32'd0, 32'd1, 32'd0, 32'd7, 32'd0);
    @(posedge clk);
    #2 in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    sb.delete();
    last_o  = 32'h0;
    last_oi = 32'h0;
    #1;
    checkOutput("async_rst_O", O, 32'h0);
    checkOutput("async_rst_Oi", Oi, 32'h0);
    checkOutput("async_rst_valid", {31'b0, out_valid}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) applyIdle();
    applyStimulus(32'd2, 32'd3, 32'd4, 32'd5, -32'sd7, 32'd22);
    repeat (3) applyIdle();

    // Reset together with in_valid: the input is dropped.
    @(posedge clk);
    #2;
    rst      = 1'b1;
    in_valid = 1'b1;
    in1      = 32'd9;
    in1i     = 32'd9;
    in2      = 32'd9;
    in2i     = 32'd9;
    last_o   = 32'h0;
    last_oi  = 32'h0;
    @(posedge clk);
    #2;
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (4) applyIdle();

    @(negedge clk);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
